// File: rtl/gbf_pingpong_ctrl.sv
// Ping-pong read scheduler for one double-buffered GBF: fill handshake per bank,
// bank selection, read strobe/address generation with per-tile replay.
module gbf_pingpong_ctrl #(
   parameter int GBF_ADDR_BITWIDTH = 5,
   parameter int GBF_DEPTH         = 32,
   parameter int REUSE_BITWIDTH    = 4,
   parameter int TILE_CNT_BITWIDTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [GBF_ADDR_BITWIDTH:0]   cfg_len,
   input  logic [REUSE_BITWIDTH-1:0]    cfg_reuse,
   input  logic                         finish,
   input  logic                         buf1_ready,
   input  logic                         buf2_ready,
   input  logic                         pe_stall,
   output logic                         buf1_need_data,
   output logic                         buf2_need_data,
   output logic                         data_avail,
   output logic                         rd_en,
   output logic                         rd_sel,
   output logic [GBF_ADDR_BITWIDTH-1:0] rd_addr,
   output logic                         done,
   output logic [TILE_CNT_BITWIDTH-1:0] tiles_done
);

   localparam int LW = GBF_ADDR_BITWIDTH + 1;
   localparam logic [LW-1:0] MAX_LEN = LW'(GBF_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DONE} state_t;

   state_t                         state_q, state_d;
   logic [LW-1:0]                  len_q, len_d;
   logic [REUSE_BITWIDTH-1:0]      reuse_q, reuse_d, pass_q, pass_d;
   logic [GBF_ADDR_BITWIDTH-1:0]   addr_q, addr_d;
   logic [1:0]                     full_q, full_d, need_q, need_d, fill_set;
   logic                           cur_q, cur_d, fin_q, fin_d, done_d;
   logic [TILE_CNT_BITWIDTH-1:0]   tiles_q, tiles_d;
   logic                           rd_go, last_addr, fin_any;

   function automatic logic active(state_t s);
      return (s == S_WAIT) || (s == S_READ);
   endfunction

   assign rd_go     = (state_q == S_READ) & ~pe_stall;
   assign last_addr = ({1'b0, addr_q} == (len_q - 1'b1));
   assign fin_any   = fin_q | finish;
   assign fill_set  = {buf2_ready & need_q[1], buf1_ready & need_q[0]};

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      reuse_d = reuse_q;
      pass_d  = pass_q;
      addr_d  = addr_q;
      full_d  = full_q | fill_set;
      cur_d   = cur_q;
      fin_d   = (state_q == S_IDLE) ? 1'b0 : fin_any;
      tiles_d = tiles_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // out-of-range lengths are clamped so the address never leaves the bank
               len_d   = (cfg_len == '0) ? LW'(1) : ((cfg_len > MAX_LEN) ? MAX_LEN : cfg_len);
               reuse_d = cfg_reuse;
               full_d  = '0;
               cur_d   = 1'b0;
               tiles_d = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fin_any) begin
               state_d = S_DONE;
            end else if (full_q[cur_q]) begin
               addr_d  = '0;
               pass_d  = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (rd_go) begin
               if (!last_addr) begin
                  addr_d = addr_q + 1'b1;
               end else if (pass_q != reuse_q) begin
                  addr_d = '0;
                  pass_d = pass_q + 1'b1;
               end else begin
                  full_d[cur_q] = 1'b0;
                  cur_d         = ~cur_q;
                  tiles_d       = tiles_q + 1'b1;
                  state_d       = fin_any ? S_DONE : S_WAIT;
               end
            end
         end
         S_DONE: begin
            fin_d   = 1'b0;
            tiles_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // need_data lags the bank flag by a cycle, drops as soon as a fill is accepted,
   // and is never raised going into or out of the stop sequence
   assign need_d = ~full_q & ~fill_set & {2{active(state_q) & active(state_d)}};
   assign done_d = (state_d == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         reuse_q <= '0;
         pass_q  <= '0;
         addr_q  <= '0;
         full_q  <= '0;
         need_q  <= '0;
         cur_q   <= 1'b0;
         fin_q   <= 1'b0;
         done    <= 1'b0;
         tiles_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         reuse_q <= reuse_d;
         pass_q  <= pass_d;
         addr_q  <= addr_d;
         full_q  <= full_d;
         need_q  <= need_d;
         cur_q   <= cur_d;
         fin_q   <= fin_d;
         done    <= done_d;
         tiles_q <= tiles_d;
      end
   end

   assign buf1_need_data = need_q[0];
   assign buf2_need_data = need_q[1];
   assign data_avail     = (state_q == S_READ);
   assign rd_en          = rd_go;
   assign rd_sel         = data_avail & cur_q;
   assign rd_addr        = data_avail ? addr_q : '0;
   assign tiles_done     = tiles_q;

endmodule

// File: tb/tb_gbf_pingpong_ctrl.sv
// Bench for gbf_pingpong_ctrl: cycle table for the basic flow, hand sequences for
// stall/reuse/finish/reset corners, and randomized runs against a read-order scoreboard.
module tb_gbf_pingpong_ctrl;

   localparam int AW = 5;
   localparam int RW = 4;
   localparam int TW = 16;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, finish = 1'b0;
   logic buf1_ready = 1'b0, buf2_ready = 1'b0, pe_stall = 1'b0;
   logic [AW:0]   cfg_len = '0;
   logic [RW-1:0] cfg_reuse = '0;
   logic buf1_need_data, buf2_need_data, data_avail, rd_en, rd_sel, done;
   logic [AW-1:0] rd_addr;
   logic [TW-1:0] tiles_done;

   int checks = 0, failures = 0;

   typedef struct {
      logic [4:0] in;   // {start, buf1_ready, buf2_ready, pe_stall, finish}
      logic [5:0] ex;   // {need1, need2, data_avail, rd_en, rd_sel, done}
      int         addr;
      int         tiles;
   } vec_t;
   vec_t tbl[16];

   int en_e[7] = '{1, 0, 0, 1, 1, 1, 0};
   int ad_e[7] = '{0, 1, 1, 1, 2, 3, 0};
   int rq[$];
   int r_len, r_reuse, r_nt, r_mism, r_viol, r_t, r_e, seen, e;
   int r_rem[2];

   gbf_pingpong_ctrl #(
      .GBF_ADDR_BITWIDTH(AW), .GBF_DEPTH(32), .REUSE_BITWIDTH(RW), .TILE_CNT_BITWIDTH(TW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .cfg_reuse(cfg_reuse),
      .finish(finish), .buf1_ready(buf1_ready), .buf2_ready(buf2_ready), .pe_stall(pe_stall),
      .buf1_need_data(buf1_need_data), .buf2_need_data(buf2_need_data),
      .data_avail(data_avail), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
      .done(done), .tiles_done(tiles_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] obs();
      return {5'd0, buf1_need_data, buf2_need_data, data_avail, rd_en, rd_sel, done, rd_addr, tiles_done};
   endfunction

   function automatic logic [31:0] rd_word();
      return {24'd0, data_avail, rd_en, rd_sel, rd_addr};
   endfunction

   task automatic row(input int i, input logic [4:0] in, input logic [5:0] ex, input int a, input int t);
      tbl[i].in = in; tbl[i].ex = ex; tbl[i].addr = a; tbl[i].tiles = t;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_run(input int len, input int reuse);
      cfg_len = (AW+1)'(len); cfg_reuse = RW'(reuse);
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic fill(input bit b1, input bit b2, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if ((!b1 || buf1_need_data) && (!b2 || buf2_need_data)) begin
            buf1_ready = b1; buf2_ready = b2; ok = 1'b1;
         end
         tick();
      end
      buf1_ready = 1'b0; buf2_ready = 1'b0;
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_dav(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (data_avail) begin ok = 1'b1; break; end
         tick();
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string name, output int t);
      bit ok = 1'b0;
      t = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; t = int'(tiles_done); end
         tick();
         if (ok) break;
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   initial begin
      // basic flow: len 4, one pass, buf1 filled in cycle 5, then finish from WAIT
      row(0,  5'b10000, 6'b000000, 0, 0);
      row(1,  5'b00000, 6'b000000, 0, 0);
      row(2,  5'b00000, 6'b110000, 0, 0);
      row(3,  5'b00000, 6'b110000, 0, 0);
      row(4,  5'b00000, 6'b110000, 0, 0);
      row(5,  5'b01000, 6'b110000, 0, 0);
      row(6,  5'b00000, 6'b010000, 0, 0);
      row(7,  5'b00000, 6'b011100, 0, 0);
      row(8,  5'b00000, 6'b011100, 1, 0);
      row(9,  5'b00000, 6'b011100, 2, 0);
      row(10, 5'b00000, 6'b011100, 3, 0);
      row(11, 5'b00000, 6'b010000, 0, 1);
      row(12, 5'b00000, 6'b110000, 0, 1);
      row(13, 5'b00001, 6'b110000, 0, 1);
      row(14, 5'b00000, 6'b000001, 0, 1);
      row(15, 5'b00000, 6'b000000, 0, 0);

      @(negedge clk);
      chk("reset_outputs", obs(), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; cfg_len = 6'd4; cfg_reuse = '0;

      for (int i = 0; i < 16; i++) begin
         {start, buf1_ready, buf2_ready, pe_stall, finish} = tbl[i].in;
         @(negedge clk);
         chk($sformatf("basic_c%0d", i), obs(),
             {5'd0, tbl[i].ex, tbl[i].addr[4:0], tbl[i].tiles[15:0]});
         tick();
      end
      {start, buf1_ready, buf2_ready, pe_stall, finish} = 5'b0;

      // stall on the 2nd and 3rd READ cycles
      start_run(4, 0);
      fill(1'b1, 1'b0, "stall_fill");
      wait_dav("stall_wait");
      for (int k = 0; k < 7; k++) begin
         pe_stall = (k == 1 || k == 2);
         @(negedge clk);
         chk($sformatf("stall_en%0d", k), 32'(rd_en), 32'(en_e[k]));
         chk($sformatf("stall_addr%0d", k), 32'(rd_addr), 32'(ad_e[k]));
         tick();
      end
      pe_stall = 1'b0;
      finish = 1'b1; tick(); finish = 1'b0;
      wait_done("stall_done", r_t);
      chk("stall_tiles", 32'(r_t), 32'd1);

      // reuse + ping-pong, ignored ready on the active bank, starvation, finish in WAIT
      start_run(3, 2);
      fill(1'b1, 1'b1, "pp_fill");
      wait_dav("pp_wait");
      for (int k = 0; k < 19; k++) begin
         buf1_ready = (k == 3);
         @(negedge clk);
         if (k == 3) chk("pp_ignored_ready_need", 32'(buf1_need_data), 32'd0);
         if (k < 9)       e = 192 + k % 3;
         else if (k == 9) e = 0;
         else             e = 224 + (k - 10) % 3;
         chk($sformatf("pp_%0d", k), rd_word(), 32'(e));
         tick();
      end
      buf1_ready = 1'b0;
      @(negedge clk);
      chk("pp_tiles", 32'(tiles_done), 32'd2);
      tick();
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (data_avail) seen++;
         tick();
      end
      chk("starve_no_avail", 32'(seen), 32'd0);
      finish = 1'b1;
      @(negedge clk);
      chk("fin_wait_nodone", 32'(done), 32'd0);
      tick(); finish = 1'b0;
      @(negedge clk);
      chk("fin_wait_done", 32'(done), 32'd1);
      tick();
      @(negedge clk);
      chk("fin_idle", {28'd0, buf1_need_data, buf2_need_data, done, data_avail}, 32'd0);
      tick();

      // finish mid-tile: both passes complete before DONE
      start_run(4, 1);
      fill(1'b1, 1'b0, "fm_fill");
      wait_dav("fm_wait");
      for (int k = 0; k < 10; k++) begin
         finish = (k == 2);
         @(negedge clk);
         if (k < 8)       chk($sformatf("fm_rd%0d", k), rd_word(), 32'(192 + k % 4));
         else if (k == 8) chk("fm_done", {14'd0, done, data_avail, tiles_done}, 32'h20001);
         else             chk("fm_idle", {28'd0, done, buf1_need_data, buf2_need_data, data_avail}, 32'd0);
         tick();
      end

      // finish arriving on the release read itself
      start_run(2, 0);
      fill(1'b1, 1'b0, "fr_fill");
      wait_dav("fr_wait");
      tick();
      finish = 1'b1;
      @(negedge clk);
      chk("fr_last_read", rd_word(), 32'd193);
      tick(); finish = 1'b0;
      @(negedge clk);
      chk("fr_done", 32'(done), 32'd1);
      tick(); tick();

      // asynchronous reset mid-READ, then a clean restart
      start_run(4, 0);
      fill(1'b1, 1'b0, "rst_fill");
      wait_dav("rst_wait");
      tick(); tick();
      chk("rst_pre_addr", 32'(rd_addr), 32'd2);
      #2 reset = 1'b0;
      #1 chk("rst_async", obs(), 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_idle", obs(), 32'd0);
      tick();
      start_run(4, 0);
      fill(1'b1, 1'b0, "rst2_fill");
      wait_dav("rst2_wait");
      @(negedge clk);
      chk("rst_restart", rd_word(), 32'd192);
      tick();
      finish = 1'b1; tick(); finish = 1'b0;
      wait_done("rst_done", r_t);

      // randomized: scoreboard of expected {bank, addr} read order
      for (int it = 0; it < 4; it++) begin
         r_len = $urandom_range(1, 8);
         r_reuse = $urandom_range(0, 2);
         r_nt = $urandom_range(2, 4);
         r_rem[0] = (r_nt + 1) / 2;
         r_rem[1] = r_nt / 2;
         r_mism = 0; r_viol = 0;
         rq.delete();
         for (int t = 0; t < r_nt; t++)
            for (int p = 0; p <= r_reuse; p++)
               for (int a = 0; a < r_len; a++)
                  rq.push_back((t % 2) * 32 + a);
         start_run(r_len, r_reuse);
         for (int c = 0; c < 3000 && rq.size() > 0; c++) begin
            pe_stall   = ($urandom_range(0, 3) == 0);
            buf1_ready = buf1_need_data && r_rem[0] > 0 && ($urandom_range(0, 2) == 0);
            buf2_ready = buf2_need_data && r_rem[1] > 0 && ($urandom_range(0, 2) == 0);
            if (buf1_ready) r_rem[0]--;
            if (buf2_ready) r_rem[1]--;
            @(negedge clk);
            if (rd_en && pe_stall) r_viol++;
            if (rd_en) begin
               r_e = rq.pop_front();
               if (r_e != int'({rd_sel, rd_addr})) r_mism++;
            end
            tick();
         end
         pe_stall = 1'b0; buf1_ready = 1'b0; buf2_ready = 1'b0;
         chk($sformatf("rand%0d_drain", it), 32'(rq.size()), 32'd0);
         chk($sformatf("rand%0d_order", it), 32'(r_mism), 32'd0);
         chk($sformatf("rand%0d_stall_en", it), 32'(r_viol), 32'd0);
         finish = 1'b1; tick(); finish = 1'b0;
         wait_done($sformatf("rand%0d_done", it), r_t);
         chk($sformatf("rand%0d_tiles", it), 32'(r_t), 32'(r_nt));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
